// File: rtl/mhp_frame_rx_if.sv
// -----------------------------------------------------------------------------
// mhp_frame_rx_if
// Bundles the byte-stream input and the decoded-frame output of mhp_frame_rx.
//
// Parameter:
//   PAYLOAD_BYTES : payload length in bytes (sets the o_payload width)
//
// Signals (direction as seen by the deserializer, modport slave):
//   i_rdata[7:0]   in   input byte
//   i_rvalid       in   input byte valid
//   o_rready       out  deserializer can accept a byte
//   o_dst/o_src    out  16-bit destination / source address
//   o_size         out  16-bit size field
//   o_dir, o_type  out  direction bit, 7-bit frame type
//   o_payload      out  payload, first byte in the top 8 bits
//   o_scs          out  received checksum field
//   o_err_scs      out  checksum mismatch (qualified by o_valid)
//   o_err_size     out  size field larger than PAYLOAD_BYTES (qualified by o_valid)
//   o_valid        out  frame available
//   i_ready        in   consumer accepts the frame
//   o_err_timeout  out  one-cycle pulse when a partial frame is discarded
//
// Modports: slave = deserializer side, master = link/consumer side.
// -----------------------------------------------------------------------------
interface mhp_frame_rx_if #(
   parameter int PAYLOAD_BYTES = 42
);
   logic [7:0]                 i_rdata;
   logic                       i_rvalid;
   logic                       o_rready;
   logic [15:0]                o_dst;
   logic [15:0]                o_src;
   logic [15:0]                o_size;
   logic                       o_dir;
   logic [6:0]                 o_type;
   logic [PAYLOAD_BYTES*8-1:0] o_payload;
   logic [15:0]                o_scs;
   logic                       o_err_scs;
   logic                       o_err_size;
   logic                       o_valid;
   logic                       i_ready;
   logic                       o_err_timeout;

   modport slave (
      input  i_rdata, i_rvalid, i_ready,
      output o_rready, o_dst, o_src, o_size, o_dir, o_type, o_payload,
             o_scs, o_err_scs, o_err_size, o_valid, o_err_timeout
   );

   modport master (
      output i_rdata, i_rvalid, i_ready,
      input  o_rready, o_dst, o_src, o_size, o_dir, o_type, o_payload,
             o_scs, o_err_scs, o_err_size, o_valid, o_err_timeout
   );
endinterface

// File: rtl/mhp_frame_rx.sv
// -----------------------------------------------------------------------------
// mhp_frame_rx
// MHP frame deserializer. Collects PAYLOAD_BYTES+9 bytes from a valid/ready
// byte stream into a frame buffer, then presents the decoded header, payload
// and status flags under a valid/ready handshake until the consumer takes it.
// A partially received frame is dropped after TIMEOUT_CYCLES idle cycles.
//
// Parameters:
//   PAYLOAD_BYTES  : payload length in bytes (>= 1)
//   TIMEOUT_CYCLES : idle cycles tolerated mid-frame (0 disables the timeout)
//
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : mhp_frame_rx_if.slave (byte input, frame output, flags)
//
// Build option:
//   MHP_SCS_CHECK_EN : when defined, a 16-bit running byte sum is compared
//                      against the received scs field to drive o_err_scs;
//                      when undefined, o_err_scs is tied to 0.
//
// Wire order (big-endian): dst[2] src[2] size[2] {dir,type} payload[N] scs[2]
// -----------------------------------------------------------------------------
module mhp_frame_rx #(
   parameter int PAYLOAD_BYTES  = 42,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          rst,
   mhp_frame_rx_if.slave bus
);
   localparam int FRAME_BYTES = PAYLOAD_BYTES + 9;
   localparam int CNT_W       = $clog2(FRAME_BYTES);
   localparam int TMO_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);
   // Abort decision is taken in the cycle the counter would step onto
   // TIMEOUT_CYCLES, so the pulse appears exactly one cycle later.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [TMO_W-1:0]         tmo_q, tmo_d;
   logic                     tmo_pulse_q, tmo_pulse_d;
   logic                     rdy_en_q;
   logic                     rready;
   logic                     valid;
   logic                     accept;
   logic                     tmo_hit;
   logic [8*FRAME_BYTES-1:0] frame_flat;   // byte k lives at [8*k +: 8]
   logic [8*PAYLOAD_BYTES-1:0] payload_w;
   logic [15:0]              size_w;
   logic [15:0]              scs_w;
   logic                     err_scs;

   assign accept  = bus.i_rvalid && rready;
   assign tmo_hit = (TIMEOUT_CYCLES > 0) && (state_q == ST_RECV) && !accept
                    && (tmo_q == TMO_LAST);

   // ---------------------------------------------------------------- FSM ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_RECV;
         ST_RECV: begin
            if (accept && (cnt_q == LAST_IDX)) state_d = ST_HOLD;
            else if (tmo_hit)                  state_d = ST_IDLE;
         end
         ST_HOLD: if (bus.i_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // o_rready is held low for the first cycle after reset via rdy_en_q.
   always_comb begin
      valid  = 1'b0;
      rready = 1'b0;
      case (state_q)
         ST_HOLD: valid  = 1'b1;
         default: rready = rdy_en_q;
      endcase
   end

   // ------------------------------------------- byte and idle counters ----
   always_comb begin
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      tmo_pulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tmo_d = '0;
            if (accept) cnt_d = CNT_W'(1);
         end
         ST_RECV: begin
            if (accept) begin
               tmo_d = '0;
               cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            end else if (tmo_hit) begin
               tmo_pulse_d = 1'b1;
               tmo_d       = '0;
               cnt_d       = '0;
            end else if (TIMEOUT_CYCLES > 0) begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            cnt_d = '0;
            tmo_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         tmo_q       <= '0;
         tmo_pulse_q <= 1'b0;
         rdy_en_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         tmo_pulse_q <= tmo_pulse_d;
         rdy_en_q    <= 1'b1;
      end
   end

   // ------------------------------------------------------ frame buffer ----
   // cnt_q is 0 in IDLE, so the write index is cnt_q in both receive states.
   for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_byte
      logic [7:0] byte_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            byte_q <= '0;
         end else if (accept && (cnt_q == CNT_W'(gi))) begin
            byte_q <= bus.i_rdata;
         end
      end
      assign frame_flat[8*gi +: 8] = byte_q;
   end

   // First payload byte (wire byte 7) goes to the most significant slot.
   for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_payload
      assign payload_w[8*(PAYLOAD_BYTES-1-gi) +: 8] = frame_flat[8*(7+gi) +: 8];
   end

   assign size_w = {frame_flat[8*4 +: 8], frame_flat[8*5 +: 8]};
   assign scs_w  = {frame_flat[8*(FRAME_BYTES-2) +: 8], frame_flat[8*(FRAME_BYTES-1) +: 8]};

   // ---------------------------------------------------------- checksum ----
`ifdef MHP_SCS_CHECK_EN
   localparam logic [CNT_W-1:0] SCS_HI_IDX = CNT_W'(FRAME_BYTES - 2);
   logic [15:0] sum_q, sum_d;

   // Sum covers bytes 0 .. FRAME_BYTES-3; restarts with the first byte.
   always_comb begin
      sum_d = sum_q;
      if (accept) begin
         if (state_q == ST_IDLE)        sum_d = {8'h00, bus.i_rdata};
         else if (cnt_q < SCS_HI_IDX)   sum_d = sum_q + {8'h00, bus.i_rdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign err_scs = valid && (sum_q != scs_w);
`else
   assign err_scs = 1'b0;
`endif

   // ----------------------------------------------------------- outputs ----
   assign bus.o_rready      = rready;
   assign bus.o_valid       = valid;
   assign bus.o_dst         = {frame_flat[8*0 +: 8], frame_flat[8*1 +: 8]};
   assign bus.o_src         = {frame_flat[8*2 +: 8], frame_flat[8*3 +: 8]};
   assign bus.o_size        = size_w;
   assign bus.o_dir         = frame_flat[8*6 + 7];
   assign bus.o_type        = frame_flat[8*6 +: 7];
   assign bus.o_payload     = payload_w;
   assign bus.o_scs         = scs_w;
   assign bus.o_err_scs     = err_scs;
   assign bus.o_err_size    = valid && (size_w > 16'(PAYLOAD_BYTES));
   assign bus.o_err_timeout = tmo_pulse_q;

endmodule

// File: tb/tb_mhp_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_mhp_frame_rx
// Directed and randomized bench for mhp_frame_rx. Instance u_a uses the
// default payload with a short timeout; u_b uses a one-byte payload.
// Expected fields come from parsing the transmitted byte array.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mhp_frame_rx;
   localparam int PA = 42;
   localparam int FA = PA + 9;
   localparam int TA = 4;
   localparam int PB = 1;
   localparam int FB = PB + 9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mhp_frame_rx_if #(.PAYLOAD_BYTES(PA)) ifa ();
   mhp_frame_rx_if #(.PAYLOAD_BYTES(PB)) ifb ();

   mhp_frame_rx #(.PAYLOAD_BYTES(PA), .TIMEOUT_CYCLES(TA)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   mhp_frame_rx #(.PAYLOAD_BYTES(PB)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] fr [FA];
   logic       early;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_valid(input bit sel, input logic v, input logic [7:0] d);
      if (sel) begin ifb.i_rvalid = v; ifb.i_rdata = d; end
      else     begin ifa.i_rvalid = v; ifa.i_rdata = d; end
   endtask

   task automatic set_ready(input bit sel, input logic r);
      if (sel) ifb.i_ready = r;
      else     ifa.i_ready = r;
   endtask

   // Random frame of n bytes; scs correct or deliberately wrong, size in or out of range.
   task automatic make_frame(input int n, input int pl, input bit good_scs, input bit big_size);
      logic [15:0] s;
      logic [15:0] sz;
      for (int k = 0; k < n; k++) fr[k] = 8'($urandom);
      sz = big_size ? 16'(pl + 1 + $urandom_range(1000)) : 16'($urandom_range(pl));
      fr[4] = sz[15:8];
      fr[5] = sz[7:0];
      s = '0;
      for (int k = 0; k < n - 2; k++) s = s + 16'(fr[k]);
      if (!good_scs) s = s + 16'($urandom_range(65535, 1));
      fr[n-2] = s[15:8];
      fr[n-1] = s[7:0];
   endtask

   // Push the first nbytes of fr, with gmin..gmax idle cycles before each byte.
   task automatic send(input bit sel, input int nbytes, input int gmin, input int gmax);
      int k;
      int budget;
      bit rdy;
      k      = 0;
      budget = 0;
      early  = 1'b0;
      while (k < nbytes && budget < 3000) begin
         repeat ($urandom_range(gmax, gmin)) begin
            set_valid(sel, 1'b0, 8'h00);
            if (sel ? ifb.o_valid : ifa.o_valid) early = 1'b1;
            tick();
            budget++;
         end
         set_valid(sel, 1'b1, fr[k]);
         rdy = sel ? ifb.o_rready : ifa.o_rready;
         if (sel ? ifb.o_valid : ifa.o_valid) early = 1'b1;
         tick();
         budget++;
         if (rdy) k++;
      end
      set_valid(sel, 1'b0, 8'h00);
      chk("send_budget", 512'(budget < 3000), 512'(1));
   endtask

   // Compare every output against fields parsed from fr[0..n-1].
   task automatic check_frame(input bit sel, input int n, input string tag);
      logic [15:0]  sum;
      logic [15:0]  size;
      logic [15:0]  scs;
      logic [511:0] pl;
      logic         exp_scs_err;
      sum = '0;
      for (int k = 0; k < n - 2; k++) sum = sum + 16'(fr[k]);
      pl = '0;
      for (int k = 7; k < n - 2; k++) pl = (pl << 8) | 512'(fr[k]);
      size = {fr[4], fr[5]};
      scs  = {fr[n-2], fr[n-1]};
`ifdef MHP_SCS_CHECK_EN
      exp_scs_err = (sum != scs);
`else
      exp_scs_err = 1'b0;
`endif
      chk({tag, ".valid"},    512'(sel ? ifb.o_valid : ifa.o_valid), 512'(1));
      chk({tag, ".early"},    512'(early), 512'(0));
      chk({tag, ".rready"},   512'(sel ? ifb.o_rready : ifa.o_rready), 512'(0));
      chk({tag, ".dst"},      512'(sel ? ifb.o_dst : ifa.o_dst), 512'({fr[0], fr[1]}));
      chk({tag, ".src"},      512'(sel ? ifb.o_src : ifa.o_src), 512'({fr[2], fr[3]}));
      chk({tag, ".size"},     512'(sel ? ifb.o_size : ifa.o_size), 512'(size));
      chk({tag, ".dir"},      512'(sel ? ifb.o_dir : ifa.o_dir), 512'(fr[6] >> 7));
      chk({tag, ".type"},     512'(sel ? ifb.o_type : ifa.o_type), 512'(fr[6] & 8'h7f));
      chk({tag, ".payload"},  sel ? 512'(ifb.o_payload) : 512'(ifa.o_payload), pl);
      chk({tag, ".scs"},      512'(sel ? ifb.o_scs : ifa.o_scs), 512'(scs));
      chk({tag, ".err_size"}, 512'(sel ? ifb.o_err_size : ifa.o_err_size), 512'(size > 16'(n - 9)));
      chk({tag, ".err_scs"},  512'(sel ? ifb.o_err_scs : ifa.o_err_scs), 512'(exp_scs_err));
   endtask

   // Handshake in one cycle; the next cycle must show valid low and ready high.
   task automatic release_frame(input bit sel, input string tag);
      set_ready(sel, 1'b1);
      tick();
      set_ready(sel, 1'b0);
      chk({tag, ".rel_valid"},  512'(sel ? ifb.o_valid : ifa.o_valid), 512'(0));
      chk({tag, ".rel_rready"}, 512'(sel ? ifb.o_rready : ifa.o_rready), 512'(1));
   endtask

   task automatic check_a_zero(input string tag);
      chk({tag, ".valid"},   512'(ifa.o_valid), 512'(0));
      chk({tag, ".rready"},  512'(ifa.o_rready), 512'(0));
      chk({tag, ".dst"},     512'(ifa.o_dst), 512'(0));
      chk({tag, ".src"},     512'(ifa.o_src), 512'(0));
      chk({tag, ".size"},    512'(ifa.o_size), 512'(0));
      chk({tag, ".type"},    512'({ifa.o_dir, ifa.o_type}), 512'(0));
      chk({tag, ".payload"}, 512'(ifa.o_payload), 512'(0));
      chk({tag, ".scs"},     512'(ifa.o_scs), 512'(0));
      chk({tag, ".errs"},    512'({ifa.o_err_scs, ifa.o_err_size, ifa.o_err_timeout}), 512'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_valid(1'b0, 1'b0, 8'h00);
      set_valid(1'b1, 1'b0, 8'h00);
      set_ready(1'b0, 1'b0);
      set_ready(1'b1, 1'b0);

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      check_a_zero("reset");
      chk("reset.b_valid",  512'(ifb.o_valid), 512'(0));
      chk("reset.b_rready", 512'(ifb.o_rready), 512'(0));
      rst = 1'b0;
      tick();
      chk("reset.a_rready_up", 512'(ifa.o_rready), 512'(1));
      chk("reset.b_rready_up", 512'(ifb.o_rready), 512'(1));

      // Reference frame, back-to-back bytes
      for (int k = 0; k < FA; k++) fr[k] = 8'h00;
      fr[0] = 8'h01; fr[1] = 8'h02; fr[2] = 8'h03; fr[3] = 8'h04;
      fr[6] = 8'h85; fr[FA-1] = 8'h8F;
      send(1'b0, FA, 0, 0);
      check_frame(1'b0, FA, "ref");
      release_frame(1'b0, "ref");

      // Wrong checksum
      fr[FA-1] = 8'h90;
      send(1'b0, FA, 0, 0);
      check_frame(1'b0, FA, "bad_scs");
      release_frame(1'b0, "bad_scs");

      // Size 43 (one above payload) and size 42 (exact limit)
      fr[FA-1] = 8'h8F;
      fr[5] = 8'h2B;
      send(1'b0, FA, 0, 0);
      check_frame(1'b0, FA, "size43");
      release_frame(1'b0, "size43");
      fr[5] = 8'h2A;
      send(1'b0, FA, 0, 0);
      check_frame(1'b0, FA, "size42");
      release_frame(1'b0, "size42");

      // Consumer stalls 10 cycles while bytes are offered
      make_frame(FA, PA, 1'b1, 1'b0);
      send(1'b0, FA, 0, 0);
      check_frame(1'b0, FA, "hold_start");
      for (int c = 0; c < 10; c++) begin
         set_valid(1'b0, 1'b1, 8'($urandom));
         tick();
         chk("hold.rready", 512'(ifa.o_rready), 512'(0));
         chk("hold.valid",  512'(ifa.o_valid), 512'(1));
      end
      check_frame(1'b0, FA, "hold_end");
      release_frame(1'b0, "hold");
      make_frame(FA, PA, 1'b0, 1'b1);
      send(1'b0, FA, 0, 0);
      check_frame(1'b0, FA, "b2b");
      release_frame(1'b0, "b2b");

      // Timeout: 5 bytes then silence; pulse exactly TA+1 cycles after last byte
      make_frame(FA, PA, 1'b1, 1'b0);
      send(1'b0, 5, 0, 0);
      for (int c = 1; c <= TA + 2; c++) begin
         chk($sformatf("tmo.pulse_b+%0d", c), 512'(ifa.o_err_timeout), 512'(c == TA + 1));
         chk($sformatf("tmo.valid_b+%0d", c), 512'(ifa.o_valid), 512'(0));
         if (c == TA + 1) chk("tmo.rready", 512'(ifa.o_rready), 512'(1));
         tick();
      end
      make_frame(FA, PA, 1'b1, 1'b0);
      send(1'b0, FA, 0, 0);
      check_frame(1'b0, FA, "after_tmo");
      release_frame(1'b0, "after_tmo");

      // Gaps of TA-1 idle cycles: byte arrives as the counter would expire
      make_frame(FA, PA, 1'b1, 1'b0);
      send(1'b0, FA, TA - 1, TA - 1);
      check_frame(1'b0, FA, "gap_limit");
      chk("gap_limit.no_tmo", 512'(ifa.o_err_timeout), 512'(0));
      release_frame(1'b0, "gap_limit");

      // Reset mid-frame after 20 bytes
      make_frame(FA, PA, 1'b1, 1'b0);
      send(1'b0, 20, 0, 0);
      rst = 1'b1;
      tick();
      check_a_zero("mid_rst");
      rst = 1'b0;
      tick();
      chk("mid_rst.rready_up", 512'(ifa.o_rready), 512'(1));
      make_frame(FA, PA, 1'b1, 1'b0);
      send(1'b0, FA, 0, 0);
      check_frame(1'b0, FA, "after_rst");
      release_frame(1'b0, "after_rst");

      // Randomized frames with random gaps below the timeout
      for (int i = 0; i < 12; i++) begin
         make_frame(FA, PA, 1'($urandom_range(1)), ($urandom_range(3) == 0));
         send(1'b0, FA, 0, $urandom_range(TA - 1));
         check_frame(1'b0, FA, $sformatf("rand%0d", i));
         release_frame(1'b0, $sformatf("rand%0d", i));
      end

      // One-byte payload, byte offered every other cycle
      for (int i = 0; i < 4; i++) begin
         make_frame(FB, PB, 1'(i % 2), (i == 2));
         send(1'b1, FB, 1, 1);
         check_frame(1'b1, FB, $sformatf("p1_%0d", i));
         chk($sformatf("p1_%0d.byte7", i), 512'(ifb.o_payload), 512'(fr[7]));
         release_frame(1'b1, $sformatf("p1_%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mhp_frame_rx.md
# mhp_frame_rx

Parametrised MHP frame deserializer: accepts an 8-bit byte stream under a valid/ready handshake and assembles a frame of `PAYLOAD_BYTES+9` bytes using an explicit byte counter. It presents the decoded header fields, payload and status flags under a valid/ready output handshake, with an inter-byte timeout. It sits between the byte-level link receiver and the MHP frame consumer, and supersedes the fixed 51-byte decoder.

## Interface
- `PAYLOAD_BYTES`, default 42: payload length in bytes, ≥1. `FRAME_BYTES = PAYLOAD_BYTES+9`.
- `TIMEOUT_CYCLES`, default 255: idle cycles allowed mid-frame before abort. 0 disables the timeout.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `i_rdata`, in, 8: input byte.
- `i_rvalid`, in, 1: input byte valid.
- `o_rready`, out, 1: block can accept a byte.
- `o_dst`, out, 16: destination address.
- `o_src`, out, 16: source address.
- `o_size`, out, 16: size field.
- `o_dir`, out, 1: direction bit.
- `o_type`, out, 7: frame type.
- `o_payload`, out, `PAYLOAD_BYTES*8`: payload. First payload byte is in bits `[8*PAYLOAD_BYTES-1 -: 8]`.
- `o_scs`, out, 16: received checksum field.
- `o_err_scs`, out, 1: checksum mismatch. Qualified by `o_valid`.
- `o_err_size`, out, 1: `o_size > PAYLOAD_BYTES`. Qualified by `o_valid`.
- `o_valid`, out, 1: frame available.
- `i_ready`, in, 1: consumer accepts the frame.
- `o_err_timeout`, out, 1: one-cycle pulse when a partial frame is discarded.

## Operation
- Wire byte order, big-endian:
  - bytes 0–1: dst
  - bytes 2–3: src
  - bytes 4–5: size
  - byte 6: `{dir, type[6:0]}`
  - bytes 7 to `FRAME_BYTES-3`: payload
  - last two bytes: scs hi, then scs lo
- A byte is accepted when `i_rvalid && o_rready`.
- States:
  - IDLE: `o_rready=1`. On an accepted byte, store it as byte 0, set `cnt=1` and go to RECV.
  - RECV: `o_rready=1`. Each accepted byte is stored at index `cnt` and `cnt` increments. When the accepted byte has `cnt==FRAME_BYTES-1`, go to HOLD.
  - HOLD: `o_rready=0`, `o_valid=1`. Outputs and flags stay stable. When `i_ready` is high, go to IDLE.
- Timeout:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` increments on every RECV cycle with no accepted byte.
  - It clears on each accepted byte and on entry to RECV.
  - When it reaches `TIMEOUT_CYCLES`: discard the partial frame, pulse `o_err_timeout` on the next cycle, go to IDLE.
  - Timeout has no effect in IDLE or HOLD.
- `o_err_size` is computed from the received size field. The frame is still delivered.
- Reset mid-frame or in HOLD discards all data.
- Reset values:
  - `o_valid`, `o_rready`, `o_err_*`: 0.
  - All field outputs: 0.
  - State: IDLE, `cnt=0`.
  - `o_rready` rises the first cycle after `rst` deasserts.

## Timing
- Last byte accepted at cycle t: `o_valid`=1 and fields and flags valid at t+1.
- Handshake (`o_valid && i_ready`) at cycle h: `o_valid`=0 and `o_rready`=1 at h+1. One bubble cycle per frame.
- Minimum frame period is `FRAME_BYTES+1` cycles, one byte per cycle.
- `o_valid` never drops without `i_ready`. No bytes are accepted while `o_valid`=1.
- Timeout: the last accepted byte at cycle b with no further `i_rvalid` gives `o_err_timeout` high at b+`TIMEOUT_CYCLES`+1 for one cycle, with `o_rready` still 1.
- A byte arriving in the same cycle the counter reaches `TIMEOUT_CYCLES` is accepted, and the abort is cancelled.

## Configuration
- `MHP_SCS_CHECK_EN` defined:
  - A 16-bit running sum (mod 2^16) of bytes 0 to `FRAME_BYTES-3` is accumulated as bytes arrive. It clears on frame start.
  - `o_err_scs = (sum != o_scs)`, valid with `o_valid`.
- `MHP_SCS_CHECK_EN` undefined: no adder is built. `o_err_scs` is constant 0, and `o_scs` is still reported.

## Test plan
- Default parameters with `MHP_SCS_CHECK_EN` defined; stream 01 02 03 04 00 00 85, then 42×00, then 00 8F, one byte per cycle. Expected: `o_dst=0x0102`, `o_src=0x0304`, `o_size=0`, `o_dir=1`, `o_type=0x05`, `o_payload=0`, `o_scs=0x008F`, `o_err_scs=0`, `o_err_size=0`. `o_valid` is high the cycle after the last byte.
- Same frame with scs 00 90: `o_err_scs=1`. Same frame with size bytes 00 2B (43): `o_err_size=1`.
- Hold `i_ready=0` for 10 cycles with `i_rvalid=1` during HOLD. Expected: `o_rready=0`, no bytes consumed, fields stable. Raise `i_ready`: `o_rready=1` on the next cycle, and a second back-to-back frame decodes correctly.
- `TIMEOUT_CYCLES=4`; send 5 bytes, then idle. Expected: `o_err_timeout` pulses 5 cycles after the last byte and no `o_valid`. A following full frame decodes correctly.
- Assert `rst` for 1 cycle after 20 bytes. Expected: all outputs 0. The next full frame decodes correctly.
- `PAYLOAD_BYTES=1` with gapped `i_rvalid` (alternate cycles). Expected: frame completes after 10 accepted bytes, and `o_payload` equals byte 7.
